// File: rtl/fb_pkg.sv
// Shared types for the framebuffer write port: pixel request record,
// write-cycle FSM states, SRAM geometry and the colour-to-SRAM-word packer.
// Latency: n/a (types only). Backpressure: n/a.
package fb_pkg;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int ADDR_W = 18;
  localparam int X_W    = 9;
  localparam int Y_W    = 9;
  localparam int RGB_W  = 15;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [RGB_W-1:0] rgb;
  } pixel_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } fbw_state_e;

  // SRAM word layout: colour in the upper 15 bits, LSB unused.
  function automatic logic [15:0] pack_rgb(input logic [RGB_W-1:0] rgb);
    return {rgb, 1'b0};
  endfunction

endpackage

// File: rtl/fb_req_fifo.sv
// Request FIFO for pixel writes; registered count, head visible on rd_data.
// Latency: a pushed entry is visible at the head one clk after the push.
// Backpressure: full blocks pushes (ignored), empty blocks pops (ignored).
// Ports: clk/rst_n, push/wr_data, pop/rd_data, full, empty, count.
module fb_req_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 33,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_writer.sv
// SRAM framebuffer write port: queues pixel writes, runs SETUP/STROBE/HOLD
// cycles only while win (blanking) is high. Latency: accept at N -> SETUP N+1,
// WE low N+2, HOLD N+3. Backpressure: in_ready = !full (plus clear in progress).
// Ports: in_* request (valid/ready), win, sram_* bus drive, bus_own, busy.
// Optional macro FB_WRITER_CLEAR_EN adds clr_req/clr_rgb full-screen clear.
module fb_writer
  import fb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XW    = 9,
  parameter int YW    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XW-1:0]     in_x,
  input  logic [YW-1:0]     in_y,
  input  logic [14:0]       in_rgb,
  input  logic              win,
`ifdef FB_WRITER_CLEAR_EN
  input  logic              clr_req,
  input  logic [14:0]       clr_rgb,
`endif
  output logic              bus_own,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  fbw_state_e        state_q, state_d;
  pixel_req_t        wr_req, head;
  logic              fifo_full, fifo_empty, fifo_pop, load;
  logic [CW-1:0]     fifo_count;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_dq;
  logic              clr_active;
  logic              cur_clr;
  logic              have_work;

  always_comb begin
    wr_req     = '0;
    wr_req.x   = in_x;
    wr_req.y   = in_y;
    wr_req.rgb = in_rgb;
  end

  fb_req_fifo #(.DEPTH(DEPTH), .W($bits(pixel_req_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid && in_ready),
    .wr_data (wr_req),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef FB_WRITER_CLEAR_EN
  localparam logic [X_W-1:0] X_LAST = X_W'(FB_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FB_H - 1);

  logic [X_W-1:0]   clr_x;
  logic [Y_W-1:0]   clr_y;
  logic [RGB_W-1:0] clr_rgb_q;

  // Sweep pointer advances when a clear write commits (SETUP->STROBE);
  // a new request restarts the sweep even if a clear write is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_active <= 1'b0;
      clr_x      <= '0;
      clr_y      <= '0;
      clr_rgb_q  <= '0;
    end else if (clr_req) begin
      clr_active <= 1'b1;
      clr_x      <= '0;
      clr_y      <= '0;
      clr_rgb_q  <= clr_rgb;
    end else if (state_q == SETUP && cur_clr && clr_active) begin
      if (clr_y == Y_LAST) begin
        clr_y <= '0;
        if (clr_x == X_LAST) begin
          clr_x      <= '0;
          clr_active <= 1'b0;
        end else begin
          clr_x <= clr_x + 1'b1;
        end
      end else begin
        clr_y <= clr_y + 1'b1;
      end
    end
  end

  assign in_ready = !fifo_full && !clr_active;
  assign busy     = (fifo_count != '0) || (state_q != IDLE) || clr_active;
`else
  assign clr_active = 1'b0;
  assign in_ready   = !fifo_full;
  assign busy       = (fifo_count != '0) || (state_q != IDLE);
`endif

  assign have_work = !fifo_empty || clr_active;

  // Clear sweep takes priority over queued pixels.
  always_comb begin
    load_addr = {head.x, head.y};
    load_dq   = pack_rgb(head.rgb);
`ifdef FB_WRITER_CLEAR_EN
    if (clr_active) begin
      load_addr = {clr_x, clr_y};
      load_dq   = pack_rgb(clr_rgb_q);
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (have_work && win) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        state_d  = STROBE;
        fifo_pop = !cur_clr;
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        if (have_work && win) begin
          state_d = SETUP;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state, so address/data only
  // change on entry to SETUP while WE is low only in STROBE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_clr     <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_we_n   <= 1'b1;
      bus_own     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sram_we_n <= (state_d != STROBE);
      bus_own   <= (state_d != IDLE);
      if (load) begin
        sram_addr   <= load_addr;
        sram_dq_out <= load_dq;
        cur_clr     <= clr_active;
      end
    end
  end

  assign sram_dq_oe = bus_own;

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: table vectors + write scoreboard.
// Latency: n/a. Backpressure: pushes hold in_valid until in_ready.
// Covers reset, single write, window gating, full FIFO, win drop, mid-write reset.
module tb_fb_writer;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_x = '0;
  logic [8:0]  in_y = '0;
  logic [14:0] in_rgb = '0;
  logic        win = 1'b0;
`ifdef FB_WRITER_CLEAR_EN
  logic        clr_req = 1'b0;
  logic [14:0] clr_rgb = '0;
`endif
  logic        bus_own;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        busy;

  fb_writer #(.DEPTH(16), .XW(9), .YW(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_rgb      (in_rgb),
    .win         (win),
`ifdef FB_WRITER_CLEAR_EN
    .clr_req     (clr_req),
    .clr_rgb     (clr_rgb),
`endif
    .bus_own     (bus_own),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [14:0] rgb;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
  } vec_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] dq;
  } exp_t;

  vec_t        tbl [6];
  exp_t        exp_q [$];
  exp_t        e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          we_pulses = 0;
  logic        prev_we_n = 1'b1;
  logic [17:0] prev_addr = '0;
  bit          sb_off = 1'b0;
  logic [17:0] last_clr_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every WE-low cycle must be a single clk, on a stable
  // address, and match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && !sram_we_n) begin
      we_pulses++;
      if (sb_off) begin
        last_clr_addr = sram_addr;
      end else begin
        check("we_single_clk", 32'(prev_we_n), 32'd1);
        check("addr_stable", 32'(sram_addr), 32'(prev_addr));
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0h, expected none", sram_addr);
        end else begin
          e = exp_q.pop_front();
          check("sb_addr", 32'(sram_addr), 32'(e.addr));
          check("sb_dq", 32'(sram_dq_out), 32'(e.dq));
        end
      end
    end
    prev_we_n = sram_we_n;
    prev_addr = sram_addr;
  end

  task automatic push(input logic [8:0] x, input logic [8:0] y, input logic [14:0] rgb,
                      input logic [17:0] ea, input logic [15:0] ed);
    int t = 0;
    @(posedge clk); #1;
    in_x = x; in_y = y; in_rgb = rgb; in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 300);
    if (!in_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back('{addr: ea, dq: ed});
    end
  endtask

  task automatic push_vec(input int i);
    push(tbl[i].x, tbl[i].y, tbl[i].rgb, tbl[i].exp_addr, tbl[i].exp_dq);
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drained_busy", 32'(busy), 32'd0);
    check("drained_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_we_low();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (sram_we_n && t < 100);
    check("we_seen", 32'(sram_we_n), 32'd0);
  endtask

  initial begin
    int base;
    int c;
    int last;

    tbl[0] = '{9'd5,   9'd7,   15'h7C00, 18'h00A07, 16'hF800};
    tbl[1] = '{9'd0,   9'd0,   15'h0001, 18'h00000, 16'h0002};
    tbl[2] = '{9'd319, 9'd239, 15'h03E0, 18'h27EEF, 16'h07C0};
    tbl[3] = '{9'd1,   9'd2,   15'h7FFF, 18'h00202, 16'hFFFE};
    tbl[4] = '{9'd100, 9'd50,  15'h1234, 18'h0C832, 16'h2468};
    tbl[5] = '{9'd256, 9'd256, 15'h5555, 18'h20100, 16'hAAAA};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_bus_own", 32'(bus_own), 32'd0);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq", 32'(sram_dq_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single write: cycle-accurate SETUP/STROBE/HOLD sequence
    win = 1'b1;
    push_vec(0);
    @(negedge clk);
    check("sw_idle_bus_own", 32'(bus_own), 32'd0);
    @(negedge clk);
    check("sw_setup_bus_own", 32'(bus_own), 32'd1);
    check("sw_setup_oe", 32'(sram_dq_oe), 32'd1);
    check("sw_setup_we_n", 32'(sram_we_n), 32'd1);
    check("sw_setup_addr", 32'(sram_addr), 32'h00A07);
    check("sw_setup_dq", 32'(sram_dq_out), 32'hF800);
    @(negedge clk);
    check("sw_strobe_we_n", 32'(sram_we_n), 32'd0);
    @(negedge clk);
    check("sw_hold_we_n", 32'(sram_we_n), 32'd1);
    check("sw_hold_bus_own", 32'(bus_own), 32'd1);
    @(negedge clk);
    check("sw_end_bus_own", 32'(bus_own), 32'd0);
    check("sw_end_oe", 32'(sram_dq_oe), 32'd0);
    drain();

    // Window gating: three queued, then back-to-back every 3 clk
    win = 1'b0;
    base = we_pulses;
    for (int i = 1; i <= 3; i++) push_vec(i);
    repeat (5) @(negedge clk);
    check("gate_no_we", 32'(we_pulses - base), 32'd0);
    check("gate_busy", 32'(busy), 32'd1);
    win = 1'b1;
    c = 0;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      do begin
        @(negedge clk);
        c++;
      end while (sram_we_n && c < 60);
      if (k > 0) check("gate_we_spacing", 32'(c - last), 32'd3);
      last = c;
    end
    drain();

    // Full FIFO: 16 stored, 17th waits for the first pop
    win = 1'b0;
    base = we_pulses;
    for (int i = 0; i < 16; i++)
      push(9'(i), 9'(i + 1), 15'(i * 3), {9'(i), 9'(i + 1)}, {15'(i * 3), 1'b0});
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      push(9'd300, 9'd200, 15'h2AAA, {9'd300, 9'd200}, 16'h5554);
      begin
        repeat (4) @(negedge clk);
        win = 1'b1;
      end
    join
    check("full_17th_after_first_pop", 32'(we_pulses - base), 32'd1);
    drain();
    check("full_total_writes", 32'(we_pulses - base), 32'd17);

    // Window drop during STROBE: current write completes, rest wait
    win = 1'b0;
    base = we_pulses;
    push_vec(4);
    push_vec(5);
    win = 1'b1;
    wait_we_low();
    win = 1'b0;
    @(negedge clk);
    check("drop_hold_bus_own", 32'(bus_own), 32'd1);
    check("drop_hold_we_n", 32'(sram_we_n), 32'd1);
    @(negedge clk);
    check("drop_idle_bus_own", 32'(bus_own), 32'd0);
    repeat (6) @(negedge clk);
    check("drop_waiting_writes", 32'(we_pulses - base), 32'd1);
    check("drop_waiting_busy", 32'(busy), 32'd1);
    win = 1'b1;
    drain();

    // Reset while WE is low
    win = 1'b0;
    push_vec(2);
    push_vec(3);
    win = 1'b1;
    wait_we_low();
    #2 rst_n = 1'b0;
    #1;
    check("rstw_we_n", 32'(sram_we_n), 32'd1);
    check("rstw_oe", 32'(sram_dq_oe), 32'd0);
    check("rstw_bus_own", 32'(bus_own), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = we_pulses;
    @(negedge clk);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    check("rstw_fifo_empty_no_writes", 32'(we_pulses - base), 32'd0);

`ifdef FB_WRITER_CLEAR_EN
    // Full-screen clear, then the queued request resumes
    win = 1'b0;
    push_vec(1);
    sb_off = 1'b1;
    base = we_pulses;
    @(posedge clk); #1;
    clr_rgb = 15'h001F;
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    win = 1'b1;
    c = 0;
    while (we_pulses - base < 76800 && c < 240000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("clr_pulses", 32'(we_pulses - base), 32'd76800);
    check("clr_last_addr", 32'(last_clr_addr), 32'({9'd319, 9'd239}));
    repeat (2) @(negedge clk);
    sb_off = 1'b0;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
